// File: rtl/flat_matrix_serializer.sv
// flat_matrix_serializer: streams a flattened ROWS x COLS matrix one element per cycle, row-major, with row/col/last tags.
// Define FLAT_MATRIX_SERIALIZER_DOUBLE_BUFFER_EN to add a shadow buffer so back-to-back matrices stream without a bubble.
module flat_matrix_serializer #(
  parameter int BIT_WIDTH = 4,
  parameter int ROWS = 8,
  parameter int COLS = 8,
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [ROWS*COLS*BIT_WIDTH-1:0] in_data,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic [BIT_WIDTH-1:0]           out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [RW-1:0]                  out_row,
  output logic [CW-1:0]                  out_col,
  output logic                           out_last
);
  localparam int MW = ROWS*COLS*BIT_WIDTH;
  typedef enum logic {IDLE, SEND} state_t;
  state_t state_q, state_d;
  logic [MW-1:0] hold_q, hold_d;
  logic [RW-1:0] r_q, r_d;
  logic [CW-1:0] c_q, c_d;
  logic [BIT_WIDTH-1:0] elem [COLS][ROWS];
  logic at_end, in_fire, xfer, end_xfer;
`ifdef FLAT_MATRIX_SERIALIZER_DOUBLE_BUFFER_EN
  logic [MW-1:0] shadow_q, shadow_d;
  logic full_q, full_d;
  assign in_ready = !full_q;
`else
  assign in_ready = state_q == IDLE;
`endif
  // Column-major storage viewed as [col][row] so the output mux is a plain array read.
  for (genvar i = 0; i < COLS; i++) begin : g_col
    for (genvar j = 0; j < ROWS; j++) begin : g_row
      assign elem[i][j] = hold_q[(i*ROWS+j)*BIT_WIDTH +: BIT_WIDTH];
    end
  end
  assign at_end    = (r_q == RW'(ROWS-1)) && (c_q == CW'(COLS-1));
  assign out_valid = state_q == SEND;
  assign out_last  = out_valid && at_end;
  assign out_row   = r_q;
  assign out_col   = c_q;
  assign out_data  = elem[c_q][r_q];
  assign xfer      = out_valid && out_ready;
  assign end_xfer  = xfer && at_end;
  assign in_fire   = in_valid && in_ready;
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    r_d     = r_q;
    c_d     = c_q;
`ifdef FLAT_MATRIX_SERIALIZER_DOUBLE_BUFFER_EN
    shadow_d = shadow_q;
    full_d   = full_q;
`endif
    if (xfer) begin
      c_d = (c_q == CW'(COLS-1)) ? '0 : c_q + 1'b1;
      r_d = (c_q != CW'(COLS-1)) ? r_q : (r_q == RW'(ROWS-1)) ? '0 : r_q + 1'b1;
      if (at_end) state_d = IDLE;
    end
    if (in_fire && (state_q == IDLE || end_xfer)) begin
      hold_d  = in_data;
      state_d = SEND;
      r_d     = '0;
      c_d     = '0;
    end
`ifdef FLAT_MATRIX_SERIALIZER_DOUBLE_BUFFER_EN
    if (in_fire && state_q == SEND && !end_xfer) begin
      shadow_d = in_data;
      full_d   = 1'b1;
    end
    // A parked matrix takes over the holding register with no idle cycle in between.
    if (end_xfer && full_q) begin
      hold_d  = shadow_q;
      full_d  = 1'b0;
      state_d = SEND;
    end
`endif
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hold_q  <= '0;
      r_q     <= '0;
      c_q     <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      r_q     <= r_d;
      c_q     <= c_d;
    end
  end
`ifdef FLAT_MATRIX_SERIALIZER_DOUBLE_BUFFER_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
      full_q   <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      full_q   <= full_d;
    end
  end
`endif
endmodule

// File: tb/tb_flat_matrix_serializer.sv
// tb_flat_matrix_serializer: checks an 8x8 serializer against a queue-based element model and a 1x1 instance against a vector table.
module tb_flat_matrix_serializer;
  localparam int BW = 4;
  localparam int R = 8;
  localparam int C = 8;
  localparam int N = R*C;
`ifdef FLAT_MATRIX_SERIALIZER_DOUBLE_BUFFER_EN
  localparam bit DB = 1'b1;
`else
  localparam bit DB = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [N*BW-1:0] in_data;
  logic in_valid, in_ready, out_valid, out_ready, out_last;
  logic [BW-1:0] out_data;
  logic [2:0] out_row, out_col;
  logic [BW-1:0] s_in_data, s_out_data;
  logic s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_out_last, s_out_row, s_out_col;
  flat_matrix_serializer #(.BIT_WIDTH(BW), .ROWS(R), .COLS(C)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_row(out_row), .out_col(out_col), .out_last(out_last));
  flat_matrix_serializer #(.BIT_WIDTH(BW), .ROWS(1), .COLS(1)) u_one (
    .clk(clk), .rst_n(rst_n), .in_data(s_in_data), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .out_data(s_out_data), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_row(s_out_row), .out_col(s_out_col), .out_last(s_out_last));
  typedef struct packed { logic [BW-1:0] d; logic [2:0] r; logic [2:0] c; logic last; } elem_t;
  typedef struct { logic iv; logic [BW-1:0] id; logic ordy; logic eir; logic ev; logic [BW-1:0] ed; logic el; } vec_t;
  elem_t q[$];
  logic [BW-1:0] m [R][C];
  int checks = 0;
  int failures = 0;
  int streak = 0;
  int max_streak = 0;
  int hs = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [N*BW-1:0] pack();
    logic [N*BW-1:0] v = '0;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        v[(c*R+r)*BW +: BW] = m[r][c];
    return v;
  endfunction
  task automatic rand_matrix();
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        m[r][c] = BW'($urandom);
    in_data = pack();
  endtask
  task automatic push_matrix();
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        q.push_back('{d: m[r][c], r: 3'(r), c: 3'(c), last: (r == R-1 && c == C-1)});
    hs++;
  endtask
  // One clock: check outputs mid-cycle against the model, then advance the model at the edge.
  task automatic step();
    logic exp_rdy, exp_vld, fin, fout;
    @(negedge clk);
    exp_vld = q.size() > 0;
    exp_rdy = DB ? (q.size() <= N) : (q.size() == 0);
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    chk("out_valid", 32'(out_valid), 32'(exp_vld));
    if (exp_vld) begin
      chk("out_data", 32'(out_data), 32'(q[0].d));
      chk("out_row", 32'(out_row), 32'(q[0].r));
      chk("out_col", 32'(out_col), 32'(q[0].c));
      chk("out_last", 32'(out_last), 32'(q[0].last));
    end else chk("out_last_idle", 32'(out_last), 32'(0));
    streak = out_valid ? streak + 1 : 0;
    if (streak > max_streak) max_streak = streak;
    fin = in_valid && exp_rdy;
    fout = exp_vld && out_ready;
    @(posedge clk);
    if (fout) void'(q.pop_front());
    if (fin) push_matrix();
    #1;
  endtask
  task automatic drain(input bit rnd, input int budget);
    int n = 0;
    in_valid = 1'b0;
    while (q.size() > 0 && n < budget) begin
      out_ready = rnd ? 1'($urandom % 2) : 1'b1;
      step();
      n++;
    end
    chk("drained", 32'(q.size()), 32'(0));
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    vec_t vt [6];
    int h0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_data = '0;
    s_in_valid = 1'b0;
    s_in_data = '0;
    s_out_ready = 1'b0;
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_in_ready", 32'(in_ready), 32'(1));
    chk("rst_out_row", 32'(out_row), 32'(0));
    chk("rst_out_col", 32'(out_col), 32'(0));
    chk("rst_out_last", 32'(out_last), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    // 1x1 instance: A then 5, each a single last-tagged element
    vt[0] = '{1'b1, 4'hA, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0};
    vt[1] = '{1'b0, 4'h0, 1'b0, DB,   1'b1, 4'hA, 1'b1};
    vt[2] = '{1'b0, 4'h0, 1'b1, DB,   1'b1, 4'hA, 1'b1};
    vt[3] = '{1'b1, 4'h5, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0};
    vt[4] = '{1'b0, 4'h0, 1'b1, DB,   1'b1, 4'h5, 1'b1};
    vt[5] = '{1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      s_in_valid = vt[i].iv;
      s_in_data = vt[i].id;
      s_out_ready = vt[i].ordy;
      @(negedge clk);
      chk($sformatf("one_in_ready[%0d]", i), 32'(s_in_ready), 32'(vt[i].eir));
      chk($sformatf("one_out_valid[%0d]", i), 32'(s_out_valid), 32'(vt[i].ev));
      chk($sformatf("one_out_last[%0d]", i), 32'(s_out_last), 32'(vt[i].el));
      chk($sformatf("one_out_row[%0d]", i), 32'(s_out_row), 32'(0));
      chk($sformatf("one_out_col[%0d]", i), 32'(s_out_col), 32'(0));
      if (vt[i].ev) chk($sformatf("one_out_data[%0d]", i), 32'(s_out_data), 32'(vt[i].ed));
      @(posedge clk);
      #1;
    end
    s_in_valid = 1'b0;
    // ordering: element (r,c) = (r*8+c)%16, out_ready held high
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        m[r][c] = BW'((r*8+c) % 16);
    in_data = pack();
    in_valid = 1'b1;
    out_ready = 1'b1;
    step();
    chk("order_handshake", 32'(hs), 32'(1));
    drain(1'b0, 200);
    step();
    // same matrix under random back-pressure
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        m[r][c] = BW'((r*8+c) % 16);
    in_data = pack();
    in_valid = 1'b1;
    step();
    drain(1'b1, 1000);
    // in_valid held with changing data while sending
    rand_matrix();
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 2*N; i++) begin
      step();
      rand_matrix();
    end
    drain(1'b0, 1000);
    // random traffic
    for (int i = 0; i < 600; i++) begin
      in_valid = ($urandom % 4) == 0;
      out_ready = ($urandom % 10) < 7;
      step();
      rand_matrix();
    end
    drain(1'b1, 2000);
    // three matrices back to back; streak shows bubble (or lack of one) between them
    step();
    max_streak = 0;
    h0 = hs;
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 400 && hs < h0 + 3; i++) begin
      step();
      rand_matrix();
    end
    chk("b2b_handshakes", 32'(hs - h0), 32'(3));
    drain(1'b0, 1000);
    chk("b2b_streak", 32'(max_streak), DB ? 32'(3*N) : 32'(N));
    // reset in the middle of a matrix
    rand_matrix();
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (10) step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'(0));
    chk("midrst_in_ready", 32'(in_ready), 32'(1));
    chk("midrst_out_row", 32'(out_row), 32'(0));
    chk("midrst_out_col", 32'(out_col), 32'(0));
    chk("midrst_out_last", 32'(out_last), 32'(0));
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step();
    rand_matrix();
    in_valid = 1'b1;
    step();
    drain(1'b1, 1000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/flat_matrix_serializer.md
Name: flat_matrix_serializer

Overview:
- Downstream consumer of the 3D-to-1D flattening stage.
- Accepts one flattened ROWS x COLS matrix of BIT_WIDTH elements on a valid/ready input.
- Emits the matrix one element per cycle, in row-major order, on a valid/ready stream with row/col tags and an end-of-matrix flag.
- Feeds per-element datapaths (MAC units, FIFOs, UART/AXI-stream bridges).

Parameters:
- BIT_WIDTH, 4, element width in bits.
- ROWS, 8, matrix rows; must be >= 1.
- COLS, 8, matrix columns; must be >= 1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  ROWS*COLS*BIT_WIDTH  flattened matrix; element (r,c) occupies bits [(c*ROWS+r)*BIT_WIDTH +: BIT_WIDTH].
- in_valid  input  1  in_data holds a valid matrix.
- in_ready  output  1  block can capture a matrix this cycle.
- out_data  output  BIT_WIDTH  current element.
- out_valid  output  1  out_data, out_row, out_col and out_last are valid.
- out_ready  input  1  consumer accepts the element this cycle.
- out_row  output  max(1,$clog2(ROWS))  row index of out_data.
- out_col  output  max(1,$clog2(COLS))  column index of out_data.
- out_last  output  1  out_data is element (ROWS-1, COLS-1).

Behaviour:
- Interface: one clock clk; reset rst_n is asynchronous, active-low.
- While rst_n=0: out_valid=0, out_row=0, out_col=0, out_last=0, holding register cleared, state=IDLE, in_ready=1 (in_ready is combinational from state).
- States:
  - IDLE: in_ready=1, out_valid=0. On in_valid && in_ready, capture in_data into the holding register, set r=0 and c=0, and go to SEND.
  - SEND: in_ready=0, out_valid=1.
- out_data = holding[(c*ROWS+r)*BIT_WIDTH +: BIT_WIDTH]; out_row=r; out_col=c; out_last=(r==ROWS-1 && c==COLS-1).
- Latency: element (0,0) is presented on out_valid in the cycle after the input handshake.
- Output transfer = out_valid && out_ready.
  - On transfer: c increments; when c==COLS-1, c wraps to 0 and r increments.
  - On a transfer with out_last=1: go to IDLE, reset r and c to 0; in_ready=1 on the next cycle.
- Back-pressure: while out_valid && !out_ready, out_data, out_row, out_col and out_last stay stable and the counters hold.
- Throughput (base build): ROWS*COLS+1 cycles per matrix when out_ready stays high.
- in_valid is ignored in SEND; in_data may change freely after capture.
- ROWS=COLS=1: single SEND cycle per matrix; out_last=1 on every element; the counters stay 0.
- Reset asserted mid-matrix: the remaining elements are discarded; on release the block is in IDLE with in_ready=1.
- No combinational path from out_ready or in_valid to out_data.

Optional Feature:
- Macro: FLAT_MATRIX_SERIALIZER_DOUBLE_BUFFER_EN.
- Defined:
  - Adds a shadow register plus a shadow_full flag (reset 0). in_ready = !shadow_full.
  - In SEND, an input handshake fills the shadow.
  - On the out_last transfer with shadow_full=1, the shadow moves to the holding register, shadow_full clears, r and c reset to 0, and the block stays in SEND. Element (0,0) of the next matrix follows with no bubble, giving ROWS*COLS cycles per matrix.
  - An input handshake in the same cycle as the out_last transfer with shadow empty loads holding directly.
- Undefined: base single-buffer behaviour above; no shadow logic is synthesised.

Test Plan:
- Reset check: assert rst_n=0 mid-SEND -> out_valid=0, out_row=0, out_col=0, out_last=0, in_ready=1 immediately; after release, a new matrix streams from (0,0).
- Ordering (BIT_WIDTH=4, ROWS=COLS=8): element (r,c) set to value (r*8+c)%16, out_ready=1 -> 64 outputs in row-major order; out_data=(r*8+c)%16; out_last only on beat 64; in_ready=1 on cycle 66 after the input handshake.
- Back-pressure: toggle out_ready with pseudo-random 50% duty -> no element dropped or duplicated; outputs stay stable while stalled; sequence identical to the ordering test.
- Input ignored: drive in_valid=1 with different data during SEND -> captured matrix unchanged; in_ready=0 throughout SEND.
- Degenerate (ROWS=COLS=1): send values 0xA then 0x5 -> outputs 0xA then 0x5, each with out_last=1, out_row=out_col=0.
- Double buffer (macro defined): in_valid held high for 3 matrices, out_ready=1 -> 192 consecutive out_valid cycles with no gap; in_ready drops while the shadow is full.
